// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-tick divider, h/v counters, coordinate request stage and aligned pixel/sync output stage.
// Optional colour-bar generator enabled by defining VGA_TEST_PATTERN_EN (adds the pattern_sel port).
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CLK_DIV  = 2,
    parameter int COLOR_W  = 8,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int X_W     = $clog2(H_TOTAL),
    localparam int Y_W     = $clog2(V_TOTAL)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [COLOR_W-1:0] r_in,
    input  logic [COLOR_W-1:0] g_in,
    input  logic [COLOR_W-1:0] b_in,
`ifdef VGA_TEST_PATTERN_EN
    input  logic               pattern_sel,
`endif
    output logic [X_W-1:0]     o_x,
    output logic [Y_W-1:0]     o_y,
    output logic               o_req,
    output logic               o_frame_start,
    output logic [COLOR_W-1:0] R,
    output logic [COLOR_W-1:0] G,
    output logic [COLOR_W-1:0] B,
    output logic               o_hs,
    output logic               o_vs,
    output logic               o_sync,
    output logic               o_blank,
    output logic               o_clk
);
    localparam int DIV_W    = $clog2(CLK_DIV);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

    logic [DIV_W-1:0]   div_q, div_d;
    logic [X_W-1:0]     h_q, h_d, x_q, x_d;
    logic [Y_W-1:0]     v_q, v_d, y_q, y_d;
    logic               tick, clk_q, clk_d;
    logic               req_q, req_d, fs_q, fs_d, hs_p1_q, hs_p1_d, vs_p1_q, vs_p1_d;
    logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic [COLOR_W-1:0] pix_r, pix_g, pix_b;
    logic               blank_q, blank_d, hs_q, hs_d, vs_q, vs_d;

`ifdef VGA_TEST_PATTERN_EN
    logic [X_W-1:0] bar;
    logic [2:0]     bar_rgb;

    // Eight equal-width bars across the visible line, ordered by descending luminance.
    always_comb begin
        bar = x_q / X_W'(H_ACTIVE / 8);
        case (bar)
            X_W'(0): bar_rgb = 3'b111;
            X_W'(1): bar_rgb = 3'b110;
            X_W'(2): bar_rgb = 3'b011;
            X_W'(3): bar_rgb = 3'b010;
            X_W'(4): bar_rgb = 3'b101;
            X_W'(5): bar_rgb = 3'b100;
            X_W'(6): bar_rgb = 3'b001;
            default: bar_rgb = 3'b000;
        endcase
        pix_r = pattern_sel ? {COLOR_W{bar_rgb[2]}} : r_in;
        pix_g = pattern_sel ? {COLOR_W{bar_rgb[1]}} : g_in;
        pix_b = pattern_sel ? {COLOR_W{bar_rgb[0]}} : b_in;
    end
`else
    always_comb begin
        pix_r = r_in;
        pix_g = g_in;
        pix_b = b_in;
    end
`endif

    always_comb begin
        tick    = (int'(div_q) == CLK_DIV - 1);
        div_d   = div_q;
        clk_d   = clk_q;
        h_d     = h_q;
        v_d     = v_q;
        x_d     = x_q;
        y_d     = y_q;
        req_d   = req_q;
        fs_d    = 1'b0;
        hs_p1_d = hs_p1_q;
        vs_p1_d = vs_p1_q;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        blank_d = blank_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        if (!en) begin
            div_d   = '0;
            clk_d   = 1'b0;
            h_d     = '0;
            v_d     = '0;
            x_d     = '0;
            y_d     = '0;
            req_d   = 1'b0;
            hs_p1_d = 1'b0;
            vs_p1_d = 1'b0;
            r_d     = '0;
            g_d     = '0;
            b_d     = '0;
            blank_d = 1'b0;
            hs_d    = ~HS_POL;
            vs_d    = ~VS_POL;
        end else begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
            clk_d = (int'(div_d) >= CLK_DIV / 2);
            if (tick) begin
                if (int'(h_q) == H_TOTAL - 1) begin
                    h_d = '0;
                    v_d = (int'(v_q) == V_TOTAL - 1) ? '0 : v_q + Y_W'(1);
                end else begin
                    h_d = h_q + X_W'(1);
                end
                // stage 1: coordinate request and per-pixel flags
                x_d     = h_q;
                y_d     = v_q;
                req_d   = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
                fs_d    = (h_q == '0) && (v_q == '0);
                hs_p1_d = (int'(h_q) >= HS_START) && (int'(h_q) < HS_END);
                vs_p1_d = (int'(v_q) >= VS_START) && (int'(v_q) < VS_END);
                // stage 2: colour capture and pins, one tick behind stage 1
                r_d     = req_q ? pix_r : '0;
                g_d     = req_q ? pix_g : '0;
                b_d     = req_q ? pix_b : '0;
                blank_d = req_q;
                hs_d    = hs_p1_q ? HS_POL : ~HS_POL;
                vs_d    = vs_p1_q ? VS_POL : ~VS_POL;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            clk_q   <= 1'b0;
            h_q     <= '0;
            v_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            req_q   <= 1'b0;
            fs_q    <= 1'b0;
            hs_p1_q <= 1'b0;
            vs_p1_q <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            blank_q <= 1'b0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
        end else begin
            div_q   <= div_d;
            clk_q   <= clk_d;
            h_q     <= h_d;
            v_q     <= v_d;
            x_q     <= x_d;
            y_q     <= y_d;
            req_q   <= req_d;
            fs_q    <= fs_d;
            hs_p1_q <= hs_p1_d;
            vs_p1_q <= vs_p1_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            blank_q <= blank_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
        end
    end

    assign o_x           = x_q;
    assign o_y           = y_q;
    assign o_req         = req_q;
    assign o_frame_start = fs_q;
    assign R             = r_q;
    assign G             = g_q;
    assign B             = b_q;
    assign o_hs          = hs_q;
    assign o_vs          = vs_q;
    assign o_sync        = 1'b0;
    assign o_blank       = blank_q;
    assign o_clk         = clk_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a 16x8 raster (visible 8x4, CLK_DIV=2); stage-2 pin values are queued at request time.
module tb_vga_timing_gen;
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       blank;
        logic       hs;
        logic       vs;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic       pat = 1'b0;
    logic [7:0] r_in, g_in, b_in;
    logic [3:0] o_x;
    logic [2:0] o_y;
    logic       o_req, o_frame_start, o_hs, o_vs, o_sync, o_blank, o_clk;
    logic [7:0] R, G, B;

    int   checks = 0;
    int   errors = 0;
    int   cyc;
    int   hs_low, vs_low, fs_cnt;
    exp_t sb[$];

    assign r_in = {4'b0000, o_x};
    assign g_in = {5'b00000, o_y};
    assign b_in = 8'hA5;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(2), .COLOR_W(8)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_sel(pat),
`endif
        .o_x(o_x), .o_y(o_y), .o_req(o_req), .o_frame_start(o_frame_start),
        .R(R), .G(G), .B(B), .o_hs(o_hs), .o_vs(o_vs), .o_sync(o_sync),
        .o_blank(o_blank), .o_clk(o_clk)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_x"}, 32'(o_x), 0);
        chk({tag, "_y"}, 32'(o_y), 0);
        chk({tag, "_req"}, 32'(o_req), 0);
        chk({tag, "_fs"}, 32'(o_frame_start), 0);
        chk({tag, "_rgb"}, {8'h00, R, G, B}, 0);
        chk({tag, "_hs"}, 32'(o_hs), 1);
        chk({tag, "_vs"}, 32'(o_vs), 1);
        chk({tag, "_sync"}, 32'(o_sync), 0);
        chk({tag, "_blank"}, 32'(o_blank), 0);
        chk({tag, "_clk"}, 32'(o_clk), 0);
    endtask

    function automatic exp_t expect_pix(input int p, input logic use_pat);
        exp_t e;
        int h, v;
        logic vis;
        logic [2:0] rgb;
        h = p % 16;
        v = (p / 16) % 8;
        vis = (h < 8) && (v < 4);
        case (h)
            0: rgb = 3'b111;
            1: rgb = 3'b110;
            2: rgb = 3'b011;
            3: rgb = 3'b010;
            4: rgb = 3'b101;
            5: rgb = 3'b100;
            6: rgb = 3'b001;
            default: rgb = 3'b000;
        endcase
        if (!vis) begin
            e.r = 8'h00; e.g = 8'h00; e.b = 8'h00;
        end else if (use_pat) begin
            e.r = {8{rgb[2]}}; e.g = {8{rgb[1]}}; e.b = {8{rgb[0]}};
        end else begin
            e.r = 8'(h); e.g = 8'(v); e.b = 8'hA5;
        end
        e.blank = vis;
        e.hs = !((h >= 10) && (h < 13));
        e.vs = !((v >= 5) && (v < 7));
        return e;
    endfunction

    task automatic model_start();
        exp_t idle;
        idle = '{r: 8'h00, g: 8'h00, b: 8'h00, blank: 1'b0, hs: 1'b1, vs: 1'b1};
        cyc = 0;
        hs_low = 0;
        vs_low = 0;
        fs_cnt = 0;
        sb.delete();
        sb.push_back(idle);
    endtask

    task automatic run_clocks(input int n);
        exp_t e;
        int p;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (o_hs === 1'b0) hs_low++;
            if (o_vs === 1'b0) vs_low++;
            if (o_frame_start === 1'b1) fs_cnt++;
            chk("o_clk", 32'(o_clk), 32'(cyc % 2));
            if (cyc % 2 == 0) begin
                p = cyc / 2 - 1;
                chk("o_x", 32'(o_x), 32'(p % 16));
                chk("o_y", 32'(o_y), 32'((p / 16) % 8));
                chk("o_req", 32'(o_req), 32'(((p % 16) < 8) && (((p / 16) % 8) < 4)));
                chk("o_frame_start", 32'(o_frame_start), 32'(p % 128 == 0));
                chk("sb_level", 32'(sb.size()), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("R", 32'(R), 32'(e.r));
                    chk("G", 32'(G), 32'(e.g));
                    chk("B", 32'(B), 32'(e.b));
                    chk("o_blank", 32'(o_blank), 32'(e.blank));
                    chk("o_hs", 32'(o_hs), 32'(e.hs));
                    chk("o_vs", 32'(o_vs), 32'(e.vs));
                end
                sb.push_back(expect_pix(p, pat));
            end else begin
                chk("fs_pulse_width", 32'(o_frame_start), 0);
            end
        end
    endtask

    // Asserts rst between clock edges, checks outputs before the next edge, releases on the falling edge.
    task automatic apply_reset(input string tag);
        #3;
        rst = 1'b1;
        #1;
        chk_reset(tag);
        @(negedge clk);
        rst = 1'b0;
        model_start();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_reset("por");
        @(negedge clk);
        rst = 1'b0;
        model_start();
        run_clocks(520);
        chk("hs_low_clocks", 32'(hs_low), 96);
        chk("vs_low_clocks", 32'(vs_low), 128);
        chk("frame_pulses", 32'(fs_cnt), 3);

`ifdef VGA_TEST_PATTERN_EN
        pat = 1'b1;
        apply_reset("pat_rst");
        run_clocks(300);
        pat = 1'b0;
`endif

        apply_reset("pre_en");
        run_clocks(76);
        chk("en_point_x", 32'(o_x), 5);
        chk("en_point_y", 32'(o_y), 2);
        en = 1'b0;
        @(posedge clk);
        #1;
        chk_reset("en_off");
        repeat (3) @(posedge clk);
        #1;
        chk_reset("en_hold");
        en = 1'b1;
        model_start();
        run_clocks(300);

        apply_reset("mid_line");
        run_clocks(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
